// File: rtl/pe_dmem_dma.sv
// Burst engine on PE data-memory port A: streams host write data straight onto the bus,
// and streams read data back through a 2-entry skid buffer sized for the 1-cycle read latency.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a host command, oCmd_Ready high
// WRITE  | forwarding host write words to port A, one per handshake
// READ   | issuing port-A reads while buffer space allows
// DRAIN  | all reads issued, emptying in-flight word and buffer
// DONE   | one-cycle completion pulse
module pe_dmem_dma #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iCmd_Valid,
    output logic                  oCmd_Ready,
    input  logic                  iCmd_Write,
    input  logic [ADDR_WIDTH-1:0] iCmd_Address,
    input  logic [LEN_WIDTH-1:0]  iCmd_Length,
    input  logic                  iWr_Valid,
    output logic                  oWr_Ready,
    input  logic [DATA_WIDTH-1:0] iWr_Data,
    output logic                  oRd_Valid,
    input  logic                  iRd_Ready,
    output logic [DATA_WIDTH-1:0] oRd_Data,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oBus_Valid,
    output logic [ADDR_WIDTH-1:0] oBus_Address,
    output logic [DATA_WIDTH-1:0] oBus_Write_Data,
    output logic                  oBus_Write_Enable,
    input  logic [DATA_WIDTH-1:0] iBus_Read_Data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN = ~(ADDR_WIDTH'(3));
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO   = '0;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;

    logic                  pop;
    logic                  push;
    logic [2:0]            occupancy;
    logic                  room;

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        remaining_d       = remaining_q;
        buf0_d            = buf0_q;
        buf1_d            = buf1_q;
        rd_ptr_d          = rd_ptr_q;
        wr_ptr_d          = wr_ptr_q;
        inflight_d        = 1'b0;
        oCmd_Ready        = 1'b0;
        oWr_Ready         = 1'b0;
        oBus_Valid        = 1'b0;
        oBus_Address      = addr_q;
        oBus_Write_Data   = '0;
        oBus_Write_Enable = 1'b0;
        oBusy             = (state_q != S_IDLE);
        oDone             = (state_q == S_DONE);

        oRd_Valid = (count_q != 2'd0);
        oRd_Data  = rd_ptr_q ? buf1_q : buf0_q;
        pop       = oRd_Valid && iRd_Ready;
        // Read data returns exactly one cycle after issue, so the in-flight flag is the push strobe.
        push      = inflight_q;

        if (push) begin
            if (wr_ptr_q) buf1_d = iBus_Read_Data;
            else          buf0_d = iBus_Read_Data;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        // A word popped this cycle frees its slot in time for a read issued now.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q};
        room      = occupancy < (3'd2 + {2'b00, pop});

        case (state_q)
            S_IDLE: begin
                oCmd_Ready = 1'b1;
                if (iCmd_Valid) begin
                    addr_d      = iCmd_Address & ADDR_ALIGN;
                    remaining_d = iCmd_Length;
                    if (iCmd_Length == LEN_ZERO) state_d = S_DONE;
                    else if (iCmd_Write)         state_d = S_WRITE;
                    else                         state_d = S_READ;
                end
            end
            S_WRITE: begin
                oWr_Ready = 1'b1;
                if (iWr_Valid) begin
                    oBus_Valid        = 1'b1;
                    oBus_Write_Enable = 1'b1;
                    oBus_Write_Data   = iWr_Data;
                    addr_d            = addr_q + ADDR_STEP;
                    remaining_d       = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) state_d = S_DONE;
                end
            end
            S_READ: begin
                if (remaining_q != LEN_ZERO && room) begin
                    oBus_Valid  = 1'b1;
                    inflight_d  = 1'b1;
                    addr_d      = addr_q + ADDR_STEP;
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight_q && count_d == 2'd0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule

// File: tb/tb_pe_dmem_dma.sv
// Scoreboard bench for pe_dmem_dma: a small port-A memory model with 1-cycle read latency,
// expected bus writes and read words queued at stimulus time and popped as the DUT produces them.
module tb_pe_dmem_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr, cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        busy, done;
    logic        bus_valid, bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [47:0] exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    int          wr_cycles[$];
    int          rd_cycles[$];
    int          done_cnt, done_cyc;
    int          first_issue, first_rdv;
    int          issues, pops;
    logic        bus_seen;
    logic        stall_prev;
    logic [31:0] held;
    logic [31:0] mem [64];

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_dmem_dma #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
        .iClk(clk), .iReset(rst),
        .iCmd_Valid(cmd_valid), .oCmd_Ready(cmd_ready), .iCmd_Write(cmd_write),
        .iCmd_Address(cmd_addr), .iCmd_Length(cmd_len),
        .iWr_Valid(wr_valid), .oWr_Ready(wr_ready), .iWr_Data(wr_data),
        .oRd_Valid(rd_valid), .iRd_Ready(rd_ready), .oRd_Data(rd_data),
        .oBusy(busy), .oDone(done),
        .oBus_Valid(bus_valid), .oBus_Address(bus_addr), .oBus_Write_Data(bus_wdata),
        .oBus_Write_Enable(bus_we), .iBus_Read_Data(bus_rdata)
    );

    // Port-A memory model: registered read, one cycle latency.
    always @(posedge clk) begin
        if (bus_valid) begin
            if (bus_we) mem[bus_addr[7:2]] <= bus_wdata;
            else        bus_rdata <= mem[bus_addr[7:2]];
        end
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [47:0] ew;
        logic [31:0] er;
        if (rst) begin
            stall_prev = 1'b0;
            issues = 0;
            pops = 0;
        end else begin
            if (bus_valid) bus_seen = 1'b1;
            if (bus_valid && bus_we) begin
                wr_cycles.push_back(cyc);
                n_vec++;
                if (exp_wr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bus_write unexpected: addr=%h data=%h, none expected", bus_addr, bus_wdata);
                end else begin
                    ew = exp_wr_q.pop_front();
                    if ({bus_addr, bus_wdata} !== ew) begin
                        n_err++;
                        $display("FAIL bus_write: got addr/data %h, expected %h", {bus_addr, bus_wdata}, ew);
                    end
                end
            end
            if (bus_valid && !bus_we && first_issue < 0) first_issue = cyc;
            if (rd_valid && first_rdv < 0) first_rdv = cyc;
            if (stall_prev) begin
                n_vec++;
                if (rd_valid !== 1'b1 || rd_data !== held) begin
                    n_err++;
                    $display("FAIL rd_stall_stable: got valid=%b data=%h, expected valid=1 data=%h", rd_valid, rd_data, held);
                end
            end
            if (busy) begin
                n_vec++;
                if (issues - pops > 2) begin
                    n_err++;
                    $display("FAIL rd_outstanding: got %0d, expected <= 2", issues - pops);
                end
            end
            if (rd_valid && rd_ready) begin
                rd_cycles.push_back(cyc);
                n_vec++;
                if (exp_rd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_data unexpected: got %h, none expected", rd_data);
                end else begin
                    er = exp_rd_q.pop_front();
                    if (rd_data !== er) begin
                        n_err++;
                        $display("FAIL rd_data: got %h, expected %h", rd_data, er);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            stall_prev = rd_valid && !rd_ready;
            held = rd_data;
            if (bus_valid && !bus_we) issues++;
            if (rd_valid && rd_ready) pops++;
        end
    end

    task automatic send_cmd(input logic w, input logic [15:0] a, input logic [15:0] l, output int acc);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_ready: got %b, expected 1", cmd_ready);
        end
        acc = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed_words(input logic [31:0] base, input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + i;
            for (k = 0; k < 50; k++) begin
                @(negedge clk);
                if (wr_ready) break;
            end
            @(posedge clk);
            #1;
            if (k == 50) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_ready timeout: got 0 for 50 cycles, expected 1");
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (k == budget) begin
            n_err++;
            $display("FAIL idle timeout: busy=%b after %0d cycles, expected 0", busy, budget);
        end
    endtask

    task automatic run_write(input logic [15:0] a, input logic [15:0] l, input logic [31:0] base);
        int acc;
        logic [15:0] ea;
        ea = a & 16'hFFFC;
        for (int i = 0; i < l; i++) begin
            exp_wr_q.push_back({ea, base + i});
            ea = ea + 16'd4;
        end
        wr_cycles.delete();
        done_cnt = 0;
        send_cmd(1'b1, a, l, acc);
        feed_words(base, int'(l));
        wait_idle(50);
        n_vec++;
        if (exp_wr_q.size() != 0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL write_burst: got %0d writes left, %0d done pulses, expected 0 and 1", exp_wr_q.size(), done_cnt);
            exp_wr_q.delete();
        end
    endtask

    task automatic run_read(input logic [15:0] a, input logic [15:0] l, input logic [31:0] base, input logic [3:0] pat);
        int acc;
        int k;
        for (int i = 0; i < l; i++) exp_rd_q.push_back(base + i);
        first_issue = -1;
        first_rdv = -1;
        done_cnt = 0;
        rd_cycles.delete();
        send_cmd(1'b0, a, l, acc);
        for (k = 0; k < 200; k++) begin
            rd_ready = pat[k % 4];
            @(negedge clk);
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rd_ready = 1'b0;
        n_vec++;
        if (k == 200 || exp_rd_q.size() != 0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL read_burst: got %0d words left, %0d done pulses, expected 0 and 1", exp_rd_q.size(), done_cnt);
            exp_rd_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({cmd_ready, busy, done, wr_ready, rd_valid, bus_valid, bus_we} !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, expected 1000000",
                     {cmd_ready, busy, done, wr_ready, rd_valid, bus_valid, bus_we});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        run_write(16'h0010, 16'd4, 32'hA0);
        n_vec++;
        if (wr_cycles.size() != 4) begin
            n_err++;
            $display("FAIL write_count: got %0d, expected 4", wr_cycles.size());
        end else begin
            n_vec++;
            if (wr_cycles[3] - wr_cycles[0] != 3) begin
                n_err++;
                $display("FAIL write_back_to_back: got span %0d, expected 3", wr_cycles[3] - wr_cycles[0]);
            end
            n_vec++;
            if (done_cyc != wr_cycles[3] + 1) begin
                n_err++;
                $display("FAIL write_done_timing: got cycle %0d, expected %0d", done_cyc, wr_cycles[3] + 1);
            end
        end
    endtask

    task automatic test_read_basic();
        run_read(16'h0010, 16'd4, 32'hA0, 4'b1111);
        n_vec++;
        if (first_rdv - first_issue != 2) begin
            n_err++;
            $display("FAIL read_latency: got %0d, expected 2", first_rdv - first_issue);
        end
        n_vec++;
        if (rd_cycles.size() != 4) begin
            n_err++;
            $display("FAIL read_count: got %0d, expected 4", rd_cycles.size());
        end else begin
            n_vec++;
            if (rd_cycles[3] - rd_cycles[0] != 3) begin
                n_err++;
                $display("FAIL read_throughput: got span %0d, expected 3", rd_cycles[3] - rd_cycles[0]);
            end
        end
    endtask

    task automatic test_read_backpressure();
        // Unaligned base: low address bits must be dropped on both bursts.
        run_write(16'h0042, 16'd8, 32'hB0);
        run_read(16'h0043, 16'd8, 32'hB0, 4'b1001);
    endtask

    task automatic test_zero_len();
        int acc;
        for (int d = 0; d < 2; d++) begin
            bus_seen = 1'b0;
            done_cnt = 0;
            send_cmd(d[0], 16'h0020, 16'd0, acc);
            wait_idle(20);
            n_vec++;
            if (done_cnt != 1 || done_cyc != acc + 1 || bus_seen !== 1'b0) begin
                n_err++;
                $display("FAIL zero_len dir=%0d: got done=%0d at +%0d bus_seen=%b, expected 1 at +1 bus_seen=0",
                         d, done_cnt, done_cyc - acc, bus_seen);
            end
        end
    endtask

    task automatic test_wrap();
        run_write(16'hFFFC, 16'd2, 32'hC0);
        run_read(16'hFFFC, 16'd2, 32'hC0, 4'b1111);
    endtask

    task automatic test_reset_mid_read();
        int acc;
        rd_ready = 1'b0;
        send_cmd(1'b0, 16'h0010, 16'd4, acc);
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if (rd_valid !== 1'b1 || issues - pops != 2) begin
            n_err++;
            $display("FAIL pre_reset_buffer: got valid=%b held=%0d, expected valid=1 held=2", rd_valid, issues - pops);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({rd_valid, busy, cmd_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL reset_mid_read: got valid/busy/cmd_ready=%b, expected 001", {rd_valid, busy, cmd_ready});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        run_read(16'h0010, 16'd4, 32'hA0, 4'b1111);
        run_write(16'h0080, 16'd3, 32'hD0);
        run_read(16'h0080, 16'd3, 32'hD0, 4'b0110);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        done_cnt = 0; done_cyc = 0; first_issue = -1; first_rdv = -1;
        issues = 0; pops = 0; bus_seen = 1'b0; stall_prev = 1'b0; held = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_write();
        test_read_basic();
        test_read_backpressure();
        test_zero_len();
        test_wrap();
        test_reset_mid_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
